// File: rtl/wave_pkg.sv
// Shared widths, window geometry and default channel colours for the
// multi-channel waveform overlay.
package wave_pkg;
   localparam int SAMPLE_W    = 8;
   localparam int ADDR_W      = 9;
   localparam int X_W         = 11;
   localparam int Y_W         = 10;
   localparam int WIN_SAMPLES = 256;
   localparam int WIN_ROWS    = 512;

   // Channel 0 occupies the low 24 bits.
   localparam logic [95:0] CH_RGB_DEFAULT = {24'h00FFFF, 24'hFF00FF, 24'h00FF00, 24'hFFFFFF};

   typedef logic [SAMPLE_W-1:0] sample_t;
   typedef logic [ADDR_W-1:0]   addr_t;

   typedef struct packed {
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
   } rgb_t;

   function automatic sample_t scale_sample(input sample_t raw, input int ofs);
      return sample_t'((raw >> 1) + sample_t'(ofs));
   endfunction
endpackage

// File: rtl/wave_channel.sv
// One waveform channel: previous/current sample pair, scaling of fresh RAM
// data, and the line/dot hit test against the current display row.
module wave_channel
   import wave_pkg::*;
#(
   parameter int AMP_OFS = 32
) (
   input  logic    clk,
   input  logic    reset,
   input  logic    update,
   input  logic    dot_mode,
   input  logic    in_window,
   input  sample_t raw,
   input  sample_t y8,
   output logic    hit
);
   sample_t prev_q, prev_d;
   sample_t curr_q, curr_d;
   sample_t lo, hi;

   always_comb begin
      prev_d = prev_q;
      curr_d = curr_q;
      if (update) begin
         prev_d = curr_q;
         curr_d = scale_sample(raw, AMP_OFS);
      end
   end

   always_comb begin
      lo = (prev_q < curr_q) ? prev_q : curr_q;
      hi = (prev_q < curr_q) ? curr_q : prev_q;
      if (dot_mode) hit = in_window && (y8 == curr_q);
      else          hit = in_window && (y8 >= lo) && (y8 <= hi);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         prev_q <= '0;
         curr_q <= '0;
      end else begin
         prev_q <= prev_d;
         curr_q <= curr_d;
      end
   end
endmodule

// File: rtl/wave_display_mc.sv
// Multi-channel oscilloscope overlay: maps the pixel column to a sample RAM
// address, tracks RAM read latency, and colours pixels on any waveform.
module wave_display_mc
   import wave_pkg::*;
#(
   parameter int          NUM_CH  = 2,
   parameter int          X_LO    = 256,
   parameter int          X_SHIFT = 1,
   parameter int          Y_LO    = 0,
   parameter int          RAM_LAT = 1,
   parameter int          AMP_OFS = 32,
   parameter logic [95:0] CH_RGB  = CH_RGB_DEFAULT
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [X_W-1:0]        x,
   input  logic [Y_W-1:0]        y,
   input  logic                  valid,
   input  logic                  read_index,
   input  logic                  dot_mode,
   input  logic [8*NUM_CH-1:0]   read_value,
   output logic [ADDR_W-1:0]     read_address,
   output logic                  valid_pixel,
   output logic [7:0]            r,
   output logic [7:0]            g,
   output logic [7:0]            b
);
   localparam logic [11:0] X_LO_V = 12'(X_LO);
   localparam logic [11:0] X_HI_V = 12'(X_LO + (WIN_SAMPLES << X_SHIFT));
   localparam logic [10:0] Y_LO_V = 11'(Y_LO);
   localparam logic [10:0] Y_HI_V = 11'(Y_LO + WIN_ROWS);

   logic                idx_lat_q, idx_lat_d;
   addr_t               last_addr_q;
   logic [RAM_LAT-1:0]  flag_q, flag_d;
   logic                armed_q, armed_d;
   logic                valid_pixel_q, valid_pixel_d;
   rgb_t                rgb_q, rgb_d;

   logic                x_ge_lo, in_window, change, update, any_hit;
   logic [X_W-1:0]      x_rel, x_col;
   logic [Y_W-1:0]      y_rel;
   sample_t             y8;
   logic [NUM_CH-1:0]   hit;
   rgb_t                win_rgb;
   logic                unused_bits;

   always_comb begin
      x_ge_lo   = {1'b0, x} >= X_LO_V;
      in_window = valid && x_ge_lo && ({1'b0, x} < X_HI_V)
                  && ({1'b0, y} >= Y_LO_V) && ({1'b0, y} < Y_HI_V);
      x_rel     = x - X_LO_V[X_W-1:0];
      x_col     = x_rel >> X_SHIFT;
      y_rel     = y - Y_LO_V[Y_W-1:0];
      y8        = y_rel[8:1];
      read_address = {idx_lat_q, x_ge_lo ? x_col[7:0] : 8'd0};
   end

   assign unused_bits = ^{x_col[X_W-1:8], y_rel[Y_W-1], y_rel[0]};

   // The RAM half is only re-latched at the top-left pixel so a frame never tears.
   always_comb begin
      idx_lat_d = (valid && (x == '0) && (y == '0)) ? read_index : idx_lat_q;
      change    = (read_address != last_addr_q);
      flag_d[0] = change;
      for (int i = 1; i < RAM_LAT; i++) flag_d[i] = flag_q[i-1];
      update    = flag_q[RAM_LAT-1];
      armed_d   = armed_q | update;
   end

   genvar gi;
   generate
      for (gi = 0; gi < NUM_CH; gi++) begin : gen_ch
         wave_channel #(.AMP_OFS(AMP_OFS)) u_ch (
            .clk       (clk),
            .reset     (reset),
            .update    (update),
            .dot_mode  (dot_mode),
            .in_window (in_window),
            .raw       (read_value[8*gi +: 8]),
            .y8        (y8),
            .hit       (hit[gi])
         );
      end
   endgenerate

   // Walk from the highest channel down so the lowest hitting channel wins.
   always_comb begin
      any_hit = 1'b0;
      win_rgb = '0;
      for (int c = NUM_CH - 1; c >= 0; c--) begin
         if (hit[c]) begin
            any_hit = 1'b1;
            win_rgb = CH_RGB[24*c +: 24];
         end
      end
      valid_pixel_d = armed_q && any_hit;
      rgb_d         = valid_pixel_d ? win_rgb : '0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         idx_lat_q     <= 1'b0;
         last_addr_q   <= '0;
         flag_q        <= '0;
         armed_q       <= 1'b0;
         valid_pixel_q <= 1'b0;
         rgb_q         <= '0;
      end else begin
         idx_lat_q     <= idx_lat_d;
         last_addr_q   <= read_address;
         flag_q        <= flag_d;
         armed_q       <= armed_d;
         valid_pixel_q <= valid_pixel_d;
         rgb_q         <= rgb_d;
      end
   end

   assign valid_pixel = valid_pixel_q;
   assign r = rgb_q.r;
   assign g = rgb_q.g;
   assign b = rgb_q.b;
endmodule

// File: tb/tb_wave_display_mc.sv
// Directed bench for wave_display_mc: default instance plus a RAM_LAT=3 copy,
// each fed by its own latency-matched RAM model.
module tb_wave_display_mc;
   logic        clk = 1'b0;
   logic        reset, valid, read_index, dot_mode;
   logic [10:0] x;
   logic [9:0]  y;
   logic [15:0] read_value, read_value3;
   logic [8:0]  read_address, read_address3;
   logic        vp, vp3;
   logic [7:0]  r, g, b, r3, g3, b3;

   logic [7:0]  mem0 [512];
   logic [7:0]  mem1 [512];
   logic [8:0]  pipe1;
   logic [8:0]  pipe3 [3];

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [10:0] x;
      logic [9:0]  y;
      logic        vld;
      logic        dot;
      logic        exp_vp;
      logic [23:0] exp_rgb;
   } vec_t;
   vec_t vecs [14];

   always #5 clk = ~clk;

   wave_display_mc u_dut (
      .clk(clk), .reset(reset), .x(x), .y(y), .valid(valid),
      .read_index(read_index), .dot_mode(dot_mode), .read_value(read_value),
      .read_address(read_address), .valid_pixel(vp), .r(r), .g(g), .b(b)
   );

   wave_display_mc #(.RAM_LAT(3)) u_dut3 (
      .clk(clk), .reset(reset), .x(x), .y(y), .valid(valid),
      .read_index(read_index), .dot_mode(dot_mode), .read_value(read_value3),
      .read_address(read_address3), .valid_pixel(vp3), .r(r3), .g(g3), .b(b3)
   );

   always @(posedge clk) begin
      pipe1    <= read_address;
      pipe3[0] <= read_address3;
      pipe3[1] <= pipe3[0];
      pipe3[2] <= pipe3[1];
   end

   always_comb begin
      read_value  = {mem1[pipe1], mem0[pipe1]};
      read_value3 = {mem1[pipe3[2]], mem0[pipe3[2]]};
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end else begin
         $display("ok   %s: %0h", name, act);
      end
   endtask

   task automatic tick(input logic [10:0] xv, input logic [9:0] yv, input logic vv);
      @(negedge clk);
      x = xv; y = yv; valid = vv;
      #1;
   endtask

   // Present one pixel, then hold the column idle so the registered result can be read.
   task automatic pix(input string name, input logic [10:0] xv, input logic [9:0] yv,
                      input logic dm, input logic evp, input logic [23:0] ergb);
      dot_mode = dm;
      tick(xv, yv, 1'b1);
      tick(xv, yv, 1'b0);
      chk(name, {7'd0, vp, r, g, b}, {7'd0, evp, ergb});
   endtask

   initial begin
      reset = 1'b1; x = '0; y = '0; valid = 1'b0; read_index = 1'b0; dot_mode = 1'b0;
      pipe1 = '0;
      for (int i = 0; i < 3; i++) pipe3[i] = '0;
      for (int i = 0; i < 512; i++) begin mem0[i] = 8'd0; mem1[i] = 8'd255; end

      vecs[0]  = '{11'd276, 10'd79,  1'b1, 1'b0, 1'b0, 24'h000000};
      vecs[1]  = '{11'd276, 10'd80,  1'b1, 1'b0, 1'b1, 24'hFFFFFF};
      vecs[2]  = '{11'd276, 10'd121, 1'b1, 1'b0, 1'b1, 24'hFFFFFF};
      vecs[3]  = '{11'd276, 10'd122, 1'b1, 1'b0, 1'b1, 24'h00FF00};
      vecs[4]  = '{11'd276, 10'd100, 1'b1, 1'b0, 1'b1, 24'hFFFFFF};
      vecs[5]  = '{11'd276, 10'd318, 1'b1, 1'b0, 1'b1, 24'h00FF00};
      vecs[6]  = '{11'd276, 10'd320, 1'b1, 1'b0, 1'b0, 24'h000000};
      vecs[7]  = '{11'd276, 10'd120, 1'b1, 1'b1, 1'b1, 24'hFFFFFF};
      vecs[8]  = '{11'd276, 10'd80,  1'b1, 1'b1, 1'b1, 24'h00FF00};
      vecs[9]  = '{11'd276, 10'd100, 1'b1, 1'b1, 1'b0, 24'h000000};
      vecs[10] = '{11'd276, 10'd600, 1'b1, 1'b0, 1'b0, 24'h000000};
      vecs[11] = '{11'd276, 10'd100, 1'b0, 1'b0, 1'b0, 24'h000000};
      vecs[12] = '{11'd767, 10'd100, 1'b1, 1'b0, 1'b1, 24'hFFFFFF};
      vecs[13] = '{11'd768, 10'd120, 1'b1, 1'b0, 1'b0, 24'h000000};

      // Reset state
      tick(11'd0, 10'd0, 1'b0);
      tick(11'd0, 10'd0, 1'b0);
      chk("rst_out", {7'd0, vp, r, g, b}, 32'd0);
      chk("rst_out3", {7'd0, vp3, r3, g3, b3}, 32'd0);
      chk("rst_addr", {23'd0, read_address}, 32'd0);
      reset = 1'b0;
      pix("blank_before_update", 11'd256, 10'd0, 1'b0, 1'b0, 24'h0);

      // Ramp on channel 0, dot mode at y8=32
      for (int i = 0; i < 512; i++) mem0[i] = 8'(i);
      dot_mode = 1'b1;
      tick(11'd1000, 10'd64, 1'b1);
      tick(11'd1000, 10'd64, 1'b1);
      tick(11'd1000, 10'd64, 1'b1);
      tick(11'd256, 10'd64, 1'b1);
      chk("ramp_addr_256", {23'd0, read_address}, 32'd0);
      tick(11'd257, 10'd64, 1'b1);
      chk("ramp_addr_257", {23'd0, read_address}, 32'd0);
      tick(11'd258, 10'd64, 1'b1);
      chk("ramp_addr_258", {23'd0, read_address}, 32'd1);
      chk("ramp_curr_a0", {24'd0, u_dut.gen_ch[0].u_ch.curr_q}, 32'd32);
      tick(11'd259, 10'd64, 1'b1);
      chk("ramp_addr_259", {23'd0, read_address}, 32'd1);
      tick(11'd259, 10'd64, 1'b1);
      chk("ramp_curr_a1", {24'd0, u_dut.gen_ch[0].u_ch.curr_q}, 32'd32);
      chk("ramp_prev_a1", {24'd0, u_dut.gen_ch[0].u_ch.prev_q}, 32'd32);
      tick(11'd259, 10'd64, 1'b0);
      chk("ramp_dot_hit", {7'd0, vp, r, g, b}, {7'd0, 1'b1, 24'hFFFFFF});
      pix("ramp_dot_miss", 11'd259, 10'd62, 1'b1, 1'b0, 24'h0);

      // Back-to-back address changes: no update may be lost at either latency
      for (int i = 0; i < 512; i++) mem0[i] = 8'(2 * i);
      for (int i = 0; i < 4; i++) tick(11'(316 + 2 * i), 10'd0, 1'b0);
      for (int i = 0; i < 4; i++) tick(11'd322, 10'd0, 1'b0);
      chk("sweep_curr", {24'd0, u_dut.gen_ch[0].u_ch.curr_q}, 32'd65);
      chk("sweep_prev", {24'd0, u_dut.gen_ch[0].u_ch.prev_q}, 32'd64);
      chk("sweep_curr3", {24'd0, u_dut3.gen_ch[0].u_ch.curr_q}, 32'd65);
      chk("sweep_prev3", {24'd0, u_dut3.gen_ch[0].u_ch.prev_q}, 32'd64);

      // Line/dot table: ch0 prev=40 curr=60, ch1 prev=159 curr=40
      for (int i = 0; i < 512; i++) begin
         mem0[i] = ((i % 256) < 10) ? 8'd16 : 8'd56;
         mem1[i] = ((i % 256) < 10) ? 8'd255 : 8'd16;
      end
      for (int i = 0; i < 3; i++) tick(11'd260, 10'd0, 1'b0);
      for (int i = 0; i < 3; i++) tick(11'd276, 10'd0, 1'b0);
      chk("tbl_prev0", {24'd0, u_dut.gen_ch[0].u_ch.prev_q}, 32'd40);
      chk("tbl_curr0", {24'd0, u_dut.gen_ch[0].u_ch.curr_q}, 32'd60);
      for (int i = 0; i < 14; i++) begin
         dot_mode = vecs[i].dot;
         tick(vecs[i].x, vecs[i].y, vecs[i].vld);
         tick(vecs[i].x, vecs[i].y, 1'b0);
         chk($sformatf("vec%0d_x%0d_y%0d", i, vecs[i].x, vecs[i].y),
             {7'd0, vp, r, g, b}, {7'd0, vecs[i].exp_vp, vecs[i].exp_rgb});
      end

      // Channel 0 flat far away: channel 1 colour shows
      for (int i = 0; i < 512; i++) begin mem0[i] = 8'd255; mem1[i] = 8'd36; end
      for (int i = 0; i < 3; i++) tick(11'd300, 10'd0, 1'b0);
      for (int i = 0; i < 3; i++) tick(11'd302, 10'd0, 1'b0);
      pix("flat_ch1_wins", 11'd302, 10'd100, 1'b0, 1'b1, 24'h00FF00);
      pix("flat_ch0_hit", 11'd302, 10'd318, 1'b0, 1'b1, 24'hFFFFFF);

      // RAM half latch only at the frame origin
      read_index = 1'b1;
      tick(11'd0, 10'd0, 1'b1);
      tick(11'd300, 10'd5, 1'b1);
      chk("idx_addr_full", {23'd0, read_address}, 32'd278);
      read_index = 1'b0;
      tick(11'd600, 10'd5, 1'b1);
      chk("idx_hold_x600", {31'd0, read_address[8]}, 32'd1);
      tick(11'd0, 10'd0, 1'b0);
      chk("idx_hold_invalid", {31'd0, read_address[8]}, 32'd1);
      tick(11'd0, 10'd1, 1'b1);
      chk("idx_hold_y1", {31'd0, read_address[8]}, 32'd1);
      tick(11'd0, 10'd0, 1'b1);
      tick(11'd300, 10'd5, 1'b1);
      chk("idx_reload", {31'd0, read_address[8]}, 32'd0);

      // Capture latency of the RAM_LAT=3 instance
      for (int i = 0; i < 512; i++) mem0[i] = 8'd0;
      for (int i = 0; i < 5; i++) tick(11'd300, 10'd0, 1'b0);
      mem0[23] = 8'd100;
      tick(11'd302, 10'd0, 1'b0);
      for (int j = 1; j <= 4; j++) begin
         tick(11'd302, 10'd0, 1'b0);
         chk($sformatf("lat3_cycle%0d", j), {24'd0, u_dut3.gen_ch[0].u_ch.curr_q},
             (j < 4) ? 32'd32 : 32'd82);
      end
      chk("lat1_captured", {24'd0, u_dut.gen_ch[0].u_ch.curr_q}, 32'd82);
      mem0[23] = 8'd200;
      for (int i = 0; i < 6; i++) tick(11'd302, 10'd0, 1'b0);
      chk("lat3_no_recapture", {24'd0, u_dut3.gen_ch[0].u_ch.curr_q}, 32'd82);
      chk("lat1_no_recapture", {24'd0, u_dut.gen_ch[0].u_ch.curr_q}, 32'd82);

      // Mid-frame reset
      for (int i = 0; i < 512; i++) begin mem0[i] = 8'd16; mem1[i] = 8'd255; end
      dot_mode = 1'b0;
      reset = 1'b1;
      tick(11'd700, 10'd100, 1'b1);
      reset = 1'b0;
      tick(11'd700, 10'd0, 1'b1);
      chk("mrst_out", {7'd0, vp, r, g, b}, 32'd0);
      chk("mrst_curr0", {24'd0, u_dut.gen_ch[0].u_ch.curr_q}, 32'd0);
      chk("mrst_prev0", {24'd0, u_dut.gen_ch[0].u_ch.prev_q}, 32'd0);
      chk("mrst_curr1", {24'd0, u_dut.gen_ch[1].u_ch.curr_q}, 32'd0);
      tick(11'd700, 10'd0, 1'b1);
      chk("mrst_black", {7'd0, vp, r, g, b}, 32'd0);
      tick(11'd710, 10'd80, 1'b1);
      tick(11'd710, 10'd80, 1'b1);
      pix("resume_hit", 11'd710, 10'd80, 1'b0, 1'b1, 24'hFFFFFF);
      pix("resume_miss", 11'd710, 10'd82, 1'b0, 1'b0, 24'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
